// File: rtl/count_sequencer_pkg.sv
// Shared types and default widths for the count_sequencer interval-timer front end.
package count_seq_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_PRESC_W = 4;
  localparam int DEF_REP_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// Host + counter-side signal bundle for count_sequencer; slave is the sequencer's view.
interface count_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W,
  parameter int REP_W   = DEF_REP_W
) ();

  logic               start;
  logic               abort;
  logic               pause;
  logic [WIDTH-1:0]   target;
  logic [PRESC_W-1:0] presc;
  logic [REP_W-1:0]   reps;
  logic [WIDTH-1:0]   cnt_val;
  logic               cnt_clr;
  logic               cnt_en;
  logic               busy;
  logic               done;
  logic [REP_W-1:0]   rep_left;

  modport slave (
    input  start, abort, pause, target, presc, reps, cnt_val,
    output cnt_clr, cnt_en, busy, done, rep_left
  );

  modport master (
    output start, abort, pause, target, presc, reps, cnt_val,
    input  cnt_clr, cnt_en, busy, done, rep_left
  );

endinterface

// File: rtl/count_sequencer_presc_tick.sv
// Prescaler phase counter: ticks when the phase reaches the latched divisor, then wraps.
module presc_tick
  import count_seq_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               hold,
  input  logic [PRESC_W-1:0] presc_q,
  output logic               tick
);

  logic [PRESC_W-1:0] phase_r;

  assign tick = (phase_r == presc_q);

  // Phase register; wrap on tick keeps presc_q = all-ones from overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= {PRESC_W{1'b0}};
    end else if (clr) begin
      phase_r <= {PRESC_W{1'b0}};
    end else if (hold) begin
      phase_r <= phase_r;
    end else if (tick) begin
      phase_r <= {PRESC_W{1'b0}};
    end else begin
      phase_r <= phase_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Interval-timer sequencer: clears and enables an external up-counter through
// repeated target intervals, with prescaling, pause and abort.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W,
  parameter int REP_W   = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  count_sequencer_if.slave bus
);

  localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

  seq_state_t         state_r;
  logic [WIDTH-1:0]   target_r;
  logic [PRESC_W-1:0] presc_r;
  logic [REP_W-1:0]   rep_left_r;
  logic               busy_r;
  logic               done_r;
  logic               cnt_clr_r;
  logic               cnt_en_s;
  logic               tick_s;
  logic               end_s;
  logic               clr_phase_s;
  logic               hold_phase_s;

  // >= rather than == so target 0 and an out-of-range counter both end the interval.
  assign end_s        = (bus.cnt_val >= target_r);
  assign clr_phase_s  = (state_r == ST_CLEAR);
  assign hold_phase_s = (state_r != ST_RUN);

  presc_tick #(
    .PRESC_W (PRESC_W)
  ) u_presc_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_phase_s),
    .hold    (hold_phase_s),
    .presc_q (presc_r),
    .tick    (tick_s)
  );

  // Count enable: a prescaler tick in RUN while the counter is still short of target.
  always_comb begin
    cnt_en_s = 1'b0;
    if ((state_r == ST_RUN) && tick_s && !end_s) begin
      cnt_en_s = 1'b1;
    end else begin
      cnt_en_s = 1'b0;
    end
  end

  // Sequencer FSM: config latch, interval/repeat bookkeeping and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      target_r   <= {WIDTH{1'b0}};
      presc_r    <= {PRESC_W{1'b0}};
      rep_left_r <= REP_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cnt_clr_r  <= 1'b0;
    end else begin
      cnt_clr_r <= 1'b0;
      done_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            target_r   <= bus.target;
            presc_r    <= bus.presc;
            rep_left_r <= (bus.reps == REP_ZERO) ? REP_ONE : bus.reps;
            cnt_clr_r  <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (bus.abort) begin
            rep_left_r <= REP_ZERO;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            rep_left_r <= REP_ZERO;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (end_s) begin
            if (rep_left_r > REP_ONE) begin
              rep_left_r <= rep_left_r - REP_ONE;
              cnt_clr_r  <= 1'b1;
              state_r    <= ST_CLEAR;
            end else begin
              rep_left_r <= REP_ZERO;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= ST_DONE;
            end
          end else if (bus.pause) begin
            state_r <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (bus.abort) begin
            rep_left_r <= REP_ZERO;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (!bus.pause) begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          rep_left_r <= REP_ZERO;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cnt_clr  = cnt_clr_r;
  assign bus.cnt_en   = cnt_en_s;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.rep_left = rep_left_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural 8-bit clear/enable counter.
module tb_count_sequencer;

  localparam int W  = 8;
  localparam int PW = 4;
  localparam int RW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [3:0]    obs_h [32];
  logic [RW-1:0] rl_h  [32];
  logic [W-1:0]  cv_h  [32];
  logic [W-1:0]  cnt_r;

  always #5 clk = ~clk;

  count_sequencer_if #(.WIDTH(W), .PRESC_W(PW), .REP_W(RW)) bus ();

  count_sequencer #(.WIDTH(W), .PRESC_W(PW), .REP_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The controlled counter: cnt_clr is its synchronous clear, cnt_en its enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt_r <= 8'd0;
    else if (bus.cnt_clr) cnt_r <= 8'd0;
    else if (bus.cnt_en)  cnt_r <= cnt_r + 8'd1;
  end
  assign bus.cnt_val = cnt_r;

  task automatic launch(input logic [W-1:0] t, input logic [PW-1:0] p, input logic [RW-1:0] r);
    bus.target = t;
    bus.presc  = p;
    bus.reps   = r;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Records cycles k+1..k+n; index i is cycle k+i. pon/poff/aon drive pause/abort after sampling.
  task automatic capture(input int n, input int pon, input int poff, input int aon);
    for (int i = 1; i <= n; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      obs_h[i] = {bus.cnt_clr, bus.cnt_en, bus.busy, bus.done};
      rl_h[i]  = bus.rep_left;
      cv_h[i]  = bus.cnt_val;
      if (i == pon)  bus.pause = 1'b1;
      if (i == poff) bus.pause = 1'b0;
      if (i == aon)  bus.abort = 1'b1;
      else           bus.abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
    bus.target = 8'd0; bus.presc = 4'd0; bus.reps = 4'd0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({bus.cnt_clr, bus.cnt_en, bus.busy, bus.done} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {bus.cnt_clr, bus.cnt_en, bus.busy, bus.done});
    end
    total++;
    if (bus.rep_left !== 4'd0) begin
      bad++; $display("FAIL reset_rep_left got=%0d want=0", bus.rep_left);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [31:0] e_clr, e_en, e_busy, e_done;
    logic [3:0]  ex;
    e_clr = 32'h2; e_en = 32'h1C; e_busy = 32'h3E; e_done = 32'h40;
    launch(8'd3, 4'd0, 4'd1);
    capture(8, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      ex = {e_clr[i], e_en[i], e_busy[i], e_done[i]};
      total++;
      if (obs_h[i] !== ex) begin
        bad++; $display("FAIL single_flags cyc=%0d clr/en/busy/done got=%b want=%b", i, obs_h[i], ex);
      end
      total++;
      if (rl_h[i] !== ((i <= 5) ? 4'd1 : 4'd0)) begin
        bad++; $display("FAIL single_rep_left cyc=%0d got=%0d want=%0d", i, rl_h[i], (i <= 5) ? 1 : 0);
      end
    end
    total++;
    if (cv_h[6] !== 8'd3) begin
      bad++; $display("FAIL single_cnt_val got=%0d want=3", cv_h[6]);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] e_clr, e_en, e_busy, e_done;
    logic [3:0]  ex;
    e_clr = 32'h2; e_en = 32'h90; e_busy = 32'h1FE; e_done = 32'h200;
    launch(8'd2, 4'd2, 4'd1);
    capture(12, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      ex = {e_clr[i], e_en[i], e_busy[i], e_done[i]};
      total++;
      if (obs_h[i] !== ex) begin
        bad++; $display("FAIL prescale_flags cyc=%0d clr/en/busy/done got=%b want=%b", i, obs_h[i], ex);
      end
    end
    total++;
    if (cv_h[12] !== 8'd2) begin
      bad++; $display("FAIL prescale_cnt_val got=%0d want=2", cv_h[12]);
    end
  endtask

  task automatic test_repeat();
    logic [31:0]   e_clr, e_en, e_busy, e_done;
    logic [3:0]    ex;
    logic [RW-1:0] erl;
    e_clr = 32'h92; e_en = 32'h124; e_busy = 32'h3FE; e_done = 32'h400;
    launch(8'd1, 4'd0, 4'd3);
    capture(12, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      ex  = {e_clr[i], e_en[i], e_busy[i], e_done[i]};
      erl = (i <= 3) ? 4'd3 : (i <= 6) ? 4'd2 : (i <= 9) ? 4'd1 : 4'd0;
      total++;
      if (obs_h[i] !== ex) begin
        bad++; $display("FAIL repeat_flags cyc=%0d clr/en/busy/done got=%b want=%b", i, obs_h[i], ex);
      end
      total++;
      if (rl_h[i] !== erl) begin
        bad++; $display("FAIL repeat_rep_left cyc=%0d got=%0d want=%0d", i, rl_h[i], erl);
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] e_clr, e_en, e_busy, e_done;
    logic [3:0]  ex;
    e_clr = 32'h2; e_en = 32'h0; e_busy = 32'h6; e_done = 32'h8;
    launch(8'd0, 4'd0, 4'd0);
    capture(6, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      ex = {e_clr[i], e_en[i], e_busy[i], e_done[i]};
      total++;
      if (obs_h[i] !== ex) begin
        bad++; $display("FAIL zero_flags cyc=%0d clr/en/busy/done got=%b want=%b", i, obs_h[i], ex);
      end
    end
    total++;
    if (rl_h[1] !== 4'd1) begin
      bad++; $display("FAIL zero_reps_as_one got=%0d want=1", rl_h[1]);
    end
  endtask

  task automatic test_pause_abort();
    logic [31:0] e_clr, e_en, e_busy, e_done;
    logic [3:0]  ex;
    e_clr = 32'h2; e_en = 32'h10C; e_busy = 32'h3FE; e_done = 32'h400;
    launch(8'd3, 4'd0, 4'd1);
    capture(12, 3, 7, 0);
    for (int i = 1; i <= 12; i++) begin
      ex = {e_clr[i], e_en[i], e_busy[i], e_done[i]};
      total++;
      if (obs_h[i] !== ex) begin
        bad++; $display("FAIL pause_flags cyc=%0d clr/en/busy/done got=%b want=%b", i, obs_h[i], ex);
      end
    end
    total++;
    if (cv_h[10] !== 8'd3) begin
      bad++; $display("FAIL pause_cnt_val got=%0d want=3", cv_h[10]);
    end
    e_en = 32'hC; e_busy = 32'hE; e_done = 32'h0;
    launch(8'd3, 4'd0, 4'd2);
    capture(8, 0, 0, 3);
    for (int i = 1; i <= 8; i++) begin
      ex = {e_clr[i], e_en[i], e_busy[i], e_done[i]};
      total++;
      if (obs_h[i] !== ex) begin
        bad++; $display("FAIL abort_flags cyc=%0d clr/en/busy/done got=%b want=%b", i, obs_h[i], ex);
      end
      total++;
      if (rl_h[i] !== ((i <= 3) ? 4'd2 : 4'd0)) begin
        bad++; $display("FAIL abort_rep_left cyc=%0d got=%0d want=%0d", i, rl_h[i], (i <= 3) ? 2 : 0);
      end
    end
    total++;
    if (cv_h[8] !== 8'd2) begin
      bad++; $display("FAIL abort_cnt_hold got=%0d want=2", cv_h[8]);
    end
  endtask

  task automatic test_presc_max();
    logic [31:0] e_clr, e_en, e_busy, e_done;
    logic [3:0]  ex;
    e_clr = 32'h2; e_en = 32'h20000; e_busy = 32'h7FFFE; e_done = 32'h80000;
    launch(8'd1, 4'd15, 4'd1);
    capture(21, 0, 0, 0);
    for (int i = 1; i <= 21; i++) begin
      ex = {e_clr[i], e_en[i], e_busy[i], e_done[i]};
      total++;
      if (obs_h[i] !== ex) begin
        bad++; $display("FAIL presc_max_flags cyc=%0d clr/en/busy/done got=%b want=%b", i, obs_h[i], ex);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] e_clr, e_en, e_busy, e_done;
    logic [3:0]  ex;
    launch(8'd5, 4'd0, 4'd2);
    capture(3, 0, 0, 0);
    bus.start = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.cnt_clr, bus.cnt_en, bus.busy, bus.done} !== 4'b0000) begin
      bad++; $display("FAIL async_reset_flags got=%b want=0000", {bus.cnt_clr, bus.cnt_en, bus.busy, bus.done});
    end
    total++;
    if (bus.rep_left !== 4'd0) begin
      bad++; $display("FAIL async_reset_rep_left got=%0d want=0", bus.rep_left);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e_clr = 32'h2; e_en = 32'hC; e_busy = 32'h1E; e_done = 32'h20;
    launch(8'd2, 4'd0, 4'd1);
    capture(8, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      ex = {e_clr[i], e_en[i], e_busy[i], e_done[i]};
      total++;
      if (obs_h[i] !== ex) begin
        bad++; $display("FAIL restart_flags cyc=%0d clr/en/busy/done got=%b want=%b", i, obs_h[i], ex);
      end
    end
    total++;
    if (cv_h[5] !== 8'd2) begin
      bad++; $display("FAIL restart_cnt_val got=%0d want=2", cv_h[5]);
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({bus.cnt_clr, bus.busy, bus.rep_left} !== 6'b000000) begin
        bad++; $display("FAIL start_abort_idle step=%0d clr/busy/rep_left got=%b want=000000", i, {bus.cnt_clr, bus.busy, bus.rep_left});
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prescale();
    test_repeat();
    test_zero();
    test_pause_abort();
    test_presc_max();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
